// File: rtl/mac_pkg.sv
// Shared accumulator helpers: signed range limits and overflow detection for
// ACC_W-bit results computed with one guard bit.
package mac_pkg;

    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // A guard bit that disagrees with the result sign means the sum left the signed range.
    function automatic logic add_ovf(input logic guard, input logic msb);
        return guard ^ msb;
    endfunction

    // Overflow direction follows the guard bit: 1 = negative overflow.
    function automatic logic clamp_low(input logic guard);
        return guard;
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational ACC_W-bit signed add with one guard bit, overflow detect and
// optional clamp to the signed bounds.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W    = 19,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [ACC_W-1:0] op_a,
    input  logic signed [ACC_W-1:0] op_b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    localparam logic signed [ACC_W-1:0] MAX_VAL = ACC_W'(acc_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_VAL = ACC_W'(acc_min(ACC_W));

    logic signed [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = (ACC_W+1)'(op_a) + (ACC_W+1)'(op_b);
        ovf      = add_ovf(wide_sum[ACC_W], wide_sum[ACC_W-1]);
        sum      = wide_sum[ACC_W-1:0];
        if (SATURATE && ovf) begin
            sum = clamp_low(wide_sum[ACC_W]) ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/mac_stream_acc.sv
// Two-stage streaming signed MAC: stage 1 registers a*b, stage 2 accumulates
// into a dot product closed by in_last and presented on a held output register.
module mac_stream_acc
    import mac_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 19,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         out_count
);

    localparam int PROD_W = 2 * DATA_W;

    logic                     en;
    logic                     accept;
    logic                     step;
    logic                     load;

    logic                     p_valid_reg;
    logic                     p_last_reg;
    logic signed [PROD_W-1:0] prod_reg;

    logic signed [ACC_W-1:0]  acc_reg;
    logic                     first_reg;
    logic                     ovf_reg;
    logic [CNT_W-1:0]         cnt_reg;

    logic                     out_valid_reg;
    logic signed [ACC_W-1:0]  out_data_reg;
    logic                     out_ovf_reg;
    logic [CNT_W-1:0]         out_count_reg;

    logic signed [ACC_W-1:0]  add_a;
    logic signed [ACC_W-1:0]  add_b;
    logic signed [ACC_W-1:0]  sum_next;
    logic                     sum_ovf;
    logic                     ovf_next;
    logic [CNT_W-1:0]         cnt_next;

    // Whole pipeline freezes only while a finished result waits on downstream.
    assign en       = !(out_valid_reg && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign step     = en && p_valid_reg;
    assign load     = step && p_last_reg;

    assign add_a    = first_reg ? '0 : acc_reg;
    assign add_b    = ACC_W'(prod_reg);
    assign ovf_next = sum_ovf | (!first_reg & ovf_reg);
    assign cnt_next = first_reg ? CNT_W'(1) : cnt_reg + CNT_W'(1);

    mac_sat_add #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .op_a (add_a),
        .op_b (add_b),
        .sum  (sum_next),
        .ovf  (sum_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_reg <= 1'b0;
            p_last_reg  <= 1'b0;
            prod_reg    <= '0;
        end else if (en) begin
            p_valid_reg <= accept;
            if (accept) begin
                p_last_reg <= in_last;
                prod_reg   <= PROD_W'(a) * PROD_W'(b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            first_reg <= 1'b1;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else if (step) begin
            ovf_reg <= ovf_next;
            cnt_reg <= cnt_next;
            if (p_last_reg) begin
                first_reg <= 1'b1;
            end else begin
                acc_reg   <= sum_next;
                first_reg <= 1'b0;
            end
        end
    end

    // A load in the handshake cycle keeps out_valid high with the new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
            out_count_reg <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sum_next;
            out_ovf_reg   <= ovf_next;
            out_count_reg <= cnt_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_mac_stream_acc.sv
// Bench for mac_stream_acc: a saturating and a wrapping instance share one
// stimulus stream; results are scored against an arithmetic dot-product model.
module tb_mac_stream_acc;

    localparam longint ACC_MAX = 262143;
    localparam longint ACC_MIN = -262144;
    localparam longint ACC_SPAN = 524288;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_last, out_ready;
    logic signed [7:0] a, b;

    logic in_ready_s, out_valid_s, out_ovf_s;
    logic signed [18:0] out_data_s;
    logic [7:0] out_count_s;
    logic in_ready_w, out_valid_w, out_ovf_w;
    logic signed [18:0] out_data_w;
    logic [7:0] out_count_w;

    always #5 clk = ~clk;

    mac_stream_acc #(.DATA_W(8), .ACC_W(19), .CNT_W(8), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_last(in_last), .a(a), .b(b), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s),
        .out_count(out_count_s));

    mac_stream_acc #(.DATA_W(8), .ACC_W(19), .CNT_W(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_last(in_last), .a(a), .b(b), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_ovf(out_ovf_w),
        .out_count(out_count_w));

    typedef struct {
        longint d;
        bit     o;
        int     c;
    } res_t;

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        longint            exp_data;
        int                exp_cnt;
        bit                exp_ovf;
    } vec_t;

    res_t q_s[$];
    res_t q_w[$];

    int checks = 0;
    int errors = 0;

    bit     m_first = 1'b1;
    longint m_acc_s = 0, m_acc_w = 0;
    bit     m_ovf_s = 0, m_ovf_w = 0;
    int     m_cnt = 0;

    bit     accepted;
    bit     rand_ready = 1'b0;
    longint cap_data_s, cap_data_w;
    bit     cap_ovf_s, cap_ovf_w;
    int     cap_cnt_s, cap_cnt_w;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    function automatic longint fit(input longint v, input bit sat);
        if (v > ACC_MAX) return sat ? ACC_MAX : v - ACC_SPAN;
        if (v < ACC_MIN) return sat ? ACC_MIN : v + ACC_SPAN;
        return v;
    endfunction

    task automatic model_step(input logic signed [7:0] av, input logic signed [7:0] bv,
                              input bit last);
        longint prod, sum_s, sum_w;
        bit o_s, o_w;
        res_t r;
        prod  = longint'(av) * longint'(bv);
        sum_s = (m_first ? 0 : m_acc_s) + prod;
        sum_w = (m_first ? 0 : m_acc_w) + prod;
        o_s   = (sum_s > ACC_MAX) || (sum_s < ACC_MIN);
        o_w   = (sum_w > ACC_MAX) || (sum_w < ACC_MIN);
        sum_s = fit(sum_s, 1'b1);
        sum_w = fit(sum_w, 1'b0);
        if (m_first) begin
            m_ovf_s = o_s;
            m_ovf_w = o_w;
            m_cnt   = 1;
        end else begin
            m_ovf_s = m_ovf_s | o_s;
            m_ovf_w = m_ovf_w | o_w;
            m_cnt   = (m_cnt + 1) % 256;
        end
        if (last) begin
            r.d = sum_s; r.o = m_ovf_s; r.c = m_cnt; q_s.push_back(r);
            r.d = sum_w; r.o = m_ovf_w; r.c = m_cnt; q_w.push_back(r);
            m_first = 1'b1;
        end else begin
            m_acc_s = sum_s;
            m_acc_w = sum_w;
            m_first = 1'b0;
        end
    endtask

    // Called at a falling edge; samples just before the next rising edge.
    task automatic tick();
        res_t r;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #4;
        accepted = 1'b0;
        if (rst_n && in_valid && in_ready_s) begin
            model_step(a, b, in_last);
            accepted = 1'b1;
        end
        if (rst_n && out_valid_s && out_ready) begin
            if (q_s.size() == 0) begin
                chk("sat_unexpected_result", out_data_s, 0);
            end else begin
                r = q_s.pop_front();
                chk("sat_data", out_data_s, r.d);
                chk("sat_ovf", out_ovf_s, r.o);
                chk("sat_count", out_count_s, r.c);
            end
            cap_data_s = out_data_s; cap_ovf_s = out_ovf_s; cap_cnt_s = out_count_s;
        end
        if (rst_n && out_valid_w && out_ready) begin
            if (q_w.size() == 0) begin
                chk("wrap_unexpected_result", out_data_w, 0);
            end else begin
                r = q_w.pop_front();
                chk("wrap_data", out_data_w, r.d);
                chk("wrap_ovf", out_ovf_w, r.o);
                chk("wrap_count", out_count_w, r.c);
            end
            cap_data_w = out_data_w; cap_ovf_w = out_ovf_w; cap_cnt_w = out_count_w;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic signed [7:0] av, input logic signed [7:0] bv,
                        input bit last);
        int n;
        a = av; b = bv; in_last = last; in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 200);
        if (!accepted) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while ((q_s.size() != 0 || q_w.size() != 0 || out_valid_s) && n < 100) begin
            tick();
            n++;
        end
        if (q_s.size() != 0 || q_w.size() != 0) chk("drain_timeout", q_s.size(), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int len, gap;

        tbl[0] = '{a: 8'sd3,    b: 8'sd4,    exp_data: 12,     exp_cnt: 1, exp_ovf: 1'b0};
        tbl[1] = '{a: -8'sd128, b: -8'sd128, exp_data: 16384,  exp_cnt: 1, exp_ovf: 1'b0};
        tbl[2] = '{a: -8'sd128, b: 8'sd127,  exp_data: -16256, exp_cnt: 1, exp_ovf: 1'b0};
        tbl[3] = '{a: 8'sd0,    b: -8'sd5,   exp_data: 0,      exp_cnt: 1, exp_ovf: 1'b0};
        tbl[4] = '{a: 8'sd127,  b: 8'sd127,  exp_data: 16129,  exp_cnt: 1, exp_ovf: 1'b0};
        tbl[5] = '{a: -8'sd1,   b: 8'sd1,    exp_data: -1,     exp_cnt: 1, exp_ovf: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid_s, 0);
        chk("reset_out_data", out_data_s, 0);
        chk("reset_out_count", out_count_s, 0);
        chk("reset_in_ready", in_ready_s, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-term dot product with latency check
        send(8'sd3, 8'sd4, 1'b0);
        send(-8'sd2, 8'sd5, 1'b0);
        send(8'sd7, -8'sd1, 1'b1);
        chk("latency_t1_low", out_valid_s, 0);
        tick();
        chk("latency_t2_high", out_valid_s, 1);
        drain();
        chk("dot3_data", cap_data_s, -5);
        chk("dot3_count", cap_cnt_s, 3);
        chk("dot3_ovf", cap_ovf_s, 0);

        // Single-term table
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].a, tbl[i].b, 1'b1);
            drain();
            chk("tbl_data", cap_data_s, tbl[i].exp_data);
            chk("tbl_count", cap_cnt_s, tbl[i].exp_cnt);
            chk("tbl_ovf", cap_ovf_s, tbl[i].exp_ovf);
        end

        // Overflow: 16 x 16384 = 262144 exceeds the 19-bit range
        for (int i = 0; i < 16; i++) send(-8'sd128, -8'sd128, i == 15);
        drain();
        chk("sat_clamp_data", cap_data_s, 262143);
        chk("sat_clamp_ovf", cap_ovf_s, 1);
        chk("wrap_data_value", cap_data_w, -262144);
        chk("wrap_ovf_flag", cap_ovf_w, 1);
        chk("ovf_count", cap_cnt_s, 16);

        // Backpressure: two results, downstream stalled
        out_ready = 1'b0;
        send(8'sd2, 8'sd2, 1'b1);
        send(8'sd1, 8'sd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready_low", in_ready_s, 0);
            chk("bp_hold_data", out_data_s, 4);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_first_result", cap_data_s, 4);
        chk("bp_second_valid", out_valid_s, 1);
        chk("bp_second_data", out_data_s, 1);
        drain();
        chk("bp_second_consumed", cap_data_s, 1);

        // Gaps inside a 10-term dot product
        for (int i = 0; i < 10; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            send(8'sd1, 8'sd1, i == 9);
        end
        drain();
        chk("gap_data", cap_data_s, 10);
        chk("gap_count", cap_cnt_s, 10);

        // Term counter wraps modulo 256
        for (int i = 0; i < 260; i++) send(8'sd0, 8'sd0, i == 259);
        drain();
        chk("cnt_wrap", cap_cnt_s, 4);

        // Reset in the middle of a dot product
        send(8'sd5, 8'sd5, 1'b0);
        send(8'sd5, 8'sd5, 1'b0);
        send(8'sd5, 8'sd5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid_s, 0);
        @(negedge clk);
        chk("midrst_out_valid_hold", out_valid_s, 0);
        rst_n = 1'b1;
        m_first = 1'b1;
        @(negedge clk);
        send(8'sd2, 8'sd3, 1'b1);
        drain();
        chk("midrst_data", cap_data_s, 6);
        chk("midrst_count", cap_cnt_s, 1);

        // Random dot products with random backpressure and gaps
        for (int d = 0; d < 25; d++) begin
            len = $urandom_range(1, 24);
            rand_ready = 1'b1;
            for (int i = 0; i < len; i++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
                send(8'($urandom), 8'($urandom), i == len - 1);
            end
        end
        drain();
        chk("final_queue_empty", q_s.size() + q_w.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
